// File: rtl/miner_pkg.sv
// Shared types and the single-byte hash step for the block_miner proof-of-work engine.
// The same hash_step function serves the RTL round and any reference model.
package miner_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_TX,
        ST_RD_HASH,
        ST_HASH,
        ST_CHECK,
        ST_WRITE,
        ST_DONE
    } state_t;

    localparam logic [7:0] HASH_ADD = 8'h3B;
    localparam int         TX_BYTES = 6;

    // One round: rotate left by one, mix in the byte, add the constant (mod 256).
    function automatic logic [7:0] hash_step(input logic [7:0] h, input logic [7:0] b);
        return ({h[6:0], h[7]} ^ b) + HASH_ADD;
    endfunction

endpackage

// File: rtl/hash_round.sv
// Combinational single-byte hash round; block_miner applies it once per HASH cycle.
module hash_round
    import miner_pkg::*;
(
    input  logic [7:0] h_in,
    input  logic [7:0] byte_in,
    output logic [7:0] h_out
);

    assign h_out = hash_step(h_in, byte_in);

endmodule

// File: rtl/block_miner.sv
// Proof-of-work engine: reads tx and previous hash from the store, searches nonces, writes the new hash back.
// Optional successful-run counter enabled by defining BLOCK_MINER_STATS_EN.
module block_miner
    import miner_pkg::*;
#(
    parameter int DIFFICULTY = 3,
    parameter int MAX_NONCE  = 255
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic [47:0] reg_result,
    output logic        reg_access_type,
    output logic        reg_wren,
    output logic [47:0] reg_data,
    output logic        busy,
    output logic        done,
    output logic        fail,
    output logic [7:0]  nonce,
    output logic [7:0]  hash,
    output logic [15:0] blocks_mined
);

    localparam int          SHIFT     = 8 - DIFFICULTY;
    localparam logic [2:0]  LAST_BYTE = 3'(TX_BYTES);
    localparam logic [7:0]  LAST_NONCE = 8'(MAX_NONCE);

    state_t      state_q, state_d;
    logic [47:0] tx_q;
    logic [7:0]  prev_q;
    logic [7:0]  h_q;
    logic [2:0]  idx_q;
    logic [7:0]  nonce_q;
    logic [7:0]  hash_q;
    logic        fail_q;

    logic [7:0]  round_byte;
    logic [7:0]  h_next;
    logic        hit;
    logic        last_nonce;

    // Bytes 0..5 come from tx (MSB first); byte 6 is the nonce.
    always_comb begin
        round_byte = nonce_q;
        for (int i = 0; i < TX_BYTES; i++) begin
            if (idx_q == 3'(i)) round_byte = tx_q[8*(TX_BYTES-1-i) +: 8];
        end
    end

    hash_round u_round (
        .h_in    (h_q),
        .byte_in (round_byte),
        .h_out   (h_next)
    );

    assign hit        = (h_q >> SHIFT) == 8'd0;
    assign last_nonce = (nonce_q == LAST_NONCE);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d         = state_q;
        busy            = (state_q != ST_IDLE);
        reg_access_type = 1'b0;
        reg_wren        = 1'b0;
        reg_data        = '0;
        done            = 1'b0;

        case (state_q)
            ST_IDLE:    if (start) state_d = ST_RD_TX;
            ST_RD_TX:   state_d = ST_RD_HASH;
            ST_RD_HASH: begin
                reg_access_type = 1'b1;
                state_d         = ST_HASH;
            end
            ST_HASH:    if (idx_q == LAST_BYTE) state_d = ST_CHECK;
            ST_CHECK: begin
                if (hit)             state_d = ST_WRITE;
                else if (!last_nonce) state_d = ST_HASH;
                else                 state_d = ST_DONE;
            end
            ST_WRITE: begin
                reg_access_type = 1'b1;
                reg_wren        = 1'b1;
                reg_data        = {40'b0, h_q};
                state_d         = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tx_q    <= '0;
            prev_q  <= '0;
            h_q     <= '0;
            idx_q   <= '0;
            nonce_q <= '0;
            hash_q  <= '0;
            fail_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE:  if (start) fail_q <= 1'b0;
                ST_RD_TX: tx_q <= reg_result;
                ST_RD_HASH: begin
                    prev_q  <= reg_result[7:0];
                    h_q     <= reg_result[7:0];
                    idx_q   <= '0;
                    nonce_q <= '0;
                end
                ST_HASH: begin
                    h_q   <= h_next;
                    idx_q <= idx_q + 3'd1;
                end
                ST_CHECK: begin
                    hash_q <= h_q;
                    if (!hit) begin
                        if (!last_nonce) begin
                            // Each attempt restarts the chain from the previous hash.
                            nonce_q <= nonce_q + 8'd1;
                            h_q     <= prev_q;
                            idx_q   <= '0;
                        end else begin
                            fail_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign nonce = nonce_q;
    assign hash  = hash_q;
    assign fail  = fail_q;

`ifdef BLOCK_MINER_STATS_EN
    logic [15:0] blocks_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            blocks_q <= '0;
        else if (state_q == ST_WRITE && blocks_q != 16'hFFFF)
            blocks_q <= blocks_q + 16'd1;
    end

    assign blocks_mined = blocks_q;
`else
    assign blocks_mined = '0;
`endif

endmodule

// File: tb/tb_block_miner.sv
// Directed bench for block_miner: three instances (difficulty/limit variants), each with its own store model.
// Scenarios: reset state, mid-run reset, restart-ignore, deep search, give-up, multi-run counter.
module tb_block_miner;
    import miner_pkg::*;

    logic        clock;
    logic        resetn;
    logic        store_rstn;
    logic [2:0]  start;
    logic [2:0]  acc, wren, busy, done, fail;
    logic [47:0] rdata  [3];
    logic [47:0] wdata  [3];
    logic [7:0]  nonce  [3];
    logic [7:0]  hash   [3];
    logic [15:0] bm     [3];
    logic [47:0] tx_cfg [3];
    logic [7:0]  st_prev[3];

    int n_cmp;
    int n_bad;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    block_miner #(.DIFFICULTY(3), .MAX_NONCE(255)) u_dut0 (
        .clock(clock), .resetn(resetn), .start(start[0]), .reg_result(rdata[0]),
        .reg_access_type(acc[0]), .reg_wren(wren[0]), .reg_data(wdata[0]),
        .busy(busy[0]), .done(done[0]), .fail(fail[0]), .nonce(nonce[0]),
        .hash(hash[0]), .blocks_mined(bm[0])
    );

    block_miner #(.DIFFICULTY(8), .MAX_NONCE(255)) u_dut1 (
        .clock(clock), .resetn(resetn), .start(start[1]), .reg_result(rdata[1]),
        .reg_access_type(acc[1]), .reg_wren(wren[1]), .reg_data(wdata[1]),
        .busy(busy[1]), .done(done[1]), .fail(fail[1]), .nonce(nonce[1]),
        .hash(hash[1]), .blocks_mined(bm[1])
    );

    block_miner #(.DIFFICULTY(8), .MAX_NONCE(16)) u_dut2 (
        .clock(clock), .resetn(resetn), .start(start[2]), .reg_result(rdata[2]),
        .reg_access_type(acc[2]), .reg_wren(wren[2]), .reg_data(wdata[2]),
        .busy(busy[2]), .done(done[2]), .fail(fail[2]), .nonce(nonce[2]),
        .hash(hash[2]), .blocks_mined(bm[2])
    );

    // Store model: tx is bench-configured, previous hash resets to FF and is written by the miner.
    always_ff @(posedge clock or negedge store_rstn) begin
        if (!store_rstn) begin
            for (int i = 0; i < 3; i++) st_prev[i] <= 8'hFF;
        end else begin
            for (int i = 0; i < 3; i++)
                if (wren[i] && acc[i]) st_prev[i] <= wdata[i][7:0];
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++)
            rdata[i] = acc[i] ? {40'b0, st_prev[i]} : tx_cfg[i];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void mine_model(input logic [47:0] tx, input logic [7:0] prev,
                                       input int diff, input int max_n,
                                       output logic [7:0] n_o, output logic [7:0] h_o,
                                       output bit f_o);
        logic [7:0] h;
        f_o = 1'b1;
        n_o = '0;
        h_o = '0;
        for (int n = 0; n <= max_n; n++) begin
            h = prev;
            for (int i = 0; i < 6; i++) h = hash_step(h, tx[47-8*i -: 8]);
            h = hash_step(h, 8'(n));
            n_o = 8'(n);
            h_o = h;
            if ((h >> (8 - diff)) == 8'd0) begin
                f_o = 1'b0;
                break;
            end
        end
    endfunction

    // Runs one mining request on instance u; cycle c is observed at the negedge after edge c-1.
    task automatic run(input int u, input int budget, input bit repulse,
                       output int wr_cyc, output int dn_cyc, output int dn_cnt,
                       output int wr_cnt, output logic [47:0] wr_data,
                       output logic fl, output logic [15:0] acc_trace);
        wr_cyc = -1; dn_cyc = -1; dn_cnt = 0; wr_cnt = 0;
        wr_data = '0; fl = 1'b0; acc_trace = '0;
        @(negedge clock);
        start[u] = 1'b1;
        @(posedge clock);
        for (int c = 1; c <= budget; c++) begin
            @(negedge clock);
            start[u] = repulse && (c <= 11);
            if (c < 16) acc_trace[c] = acc[u];
            if (wren[u]) begin
                wr_cnt++;
                wr_cyc  = c;
                wr_data = wdata[u];
            end
            if (done[u]) begin
                dn_cnt++;
                if (dn_cyc < 0) dn_cyc = c;
                fl = fail[u];
            end
            if (!busy[u] && dn_cnt > 0) break;
        end
        start[u] = 1'b0;
    endtask

    int           wr_cyc, dn_cyc, dn_cnt, wr_cnt;
    logic [47:0]  wr_data;
    logic         fl;
    logic [15:0]  acc_tr;
    logic [7:0]   m_n, m_h;
    bit           m_f;
    logic [47:0]  run_tx [2];
    logic [15:0]  exp_bm;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        start = '0;
        resetn = 1'b0;
        store_rstn = 1'b0;
        for (int i = 0; i < 3; i++) tx_cfg[i] = '0;
        run_tx[0] = 48'h0123_4567_89AB;
        run_tx[1] = 48'hDEAD_BEEF_CAFE;

        repeat (3) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        store_rstn = 1'b1;
        @(negedge clock);

        for (int u = 0; u < 3; u++) begin
            check($sformatf("rst_busy%0d", u),  busy[u],  1'b0);
            check($sformatf("rst_done%0d", u),  done[u],  1'b0);
            check($sformatf("rst_fail%0d", u),  fail[u],  1'b0);
            check($sformatf("rst_acc%0d", u),   acc[u],   1'b0);
            check($sformatf("rst_wren%0d", u),  wren[u],  1'b0);
            check($sformatf("rst_data%0d", u),  wdata[u], 48'h0);
            check($sformatf("rst_nonce%0d", u), nonce[u], 8'h0);
            check($sformatf("rst_hash%0d", u),  hash[u],  8'h0);
            check($sformatf("rst_bm%0d", u),    bm[u],    16'h0);
        end

        // Reset asserted in cycle 7 of a run: everything drops at once, nothing written.
        wr_cnt = 0;
        @(negedge clock);
        start[0] = 1'b1;
        @(posedge clock);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clock);
            start[0] = 1'b0;
            if (wren[0]) wr_cnt++;
            if (c == 6) check("midrst_busy_before", busy[0], 1'b1);
        end
        resetn = 1'b0;
        #1;
        check("midrst_busy", busy[0], 1'b0);
        check("midrst_wren", wren[0], 1'b0);
        check("midrst_acc",  acc[0],  1'b0);
        check("midrst_data", wdata[0], 48'h0);
        check("midrst_done", done[0], 1'b0);
        check("midrst_nonce", nonce[0], 8'h0);
        check("midrst_hash", hash[0], 8'h0);
        check("midrst_writes", wr_cnt, 0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        repeat (3) @(negedge clock);
        check("midrst_store", st_prev[0], 8'hFF);
        check("midrst_idle", busy[0], 1'b0);

        // Difficulty 3 from reset store, start re-pulsed during the run.
        run(0, 40, 1'b1, wr_cyc, dn_cyc, dn_cnt, wr_cnt, wr_data, fl, acc_tr);
        check("s1_write_cyc", wr_cyc, 11);
        check("s1_write_cnt", wr_cnt, 1);
        check("s1_write_data", wr_data, 48'h1D);
        check("s1_done_cyc", dn_cyc, 12);
        check("s1_done_cnt", dn_cnt, 1);
        check("s1_fail", fl, 1'b0);
        check("s1_acc_trace", acc_tr, 16'h0804);
        check("s1_nonce", nonce[0], 8'h00);
        check("s1_hash", hash[0], 8'h1D);
        check("s1_store", st_prev[0], 8'h1D);
        repeat (3) @(negedge clock);
        check("s1_no_requeue", busy[0], 1'b0);

        // Difficulty 8: only hash 00 qualifies.
        run(1, 400, 1'b0, wr_cyc, dn_cyc, dn_cnt, wr_cnt, wr_data, fl, acc_tr);
        check("s2_write_cyc", wr_cyc, 323);
        check("s2_write_data", wr_data, 48'h0);
        check("s2_done_cyc", dn_cyc, 324);
        check("s2_fail", fl, 1'b0);
        check("s2_nonce", nonce[1], 8'h27);
        check("s2_hash", hash[1], 8'h00);
        check("s2_store", st_prev[1], 8'h00);

        // Difficulty 8 with nonce limit 16: gives up without writing.
        run(2, 200, 1'b0, wr_cyc, dn_cyc, dn_cnt, wr_cnt, wr_data, fl, acc_tr);
        check("s3_done_cyc", dn_cyc, 139);
        check("s3_done_cnt", dn_cnt, 1);
        check("s3_fail", fl, 1'b1);
        check("s3_fail_hold", fail[2], 1'b1);
        check("s3_write_cnt", wr_cnt, 0);
        check("s3_nonce", nonce[2], 8'h10);
        check("s3_hash", hash[2], 8'h2D);
        check("s3_store", st_prev[2], 8'hFF);

        // Two more successful runs on instance 0 with fresh transactions.
        for (int r = 0; r < 2; r++) begin
            tx_cfg[0] = run_tx[r];
            mine_model(run_tx[r], st_prev[0], 3, 255, m_n, m_h, m_f);
            run(0, 3000, 1'b0, wr_cyc, dn_cyc, dn_cnt, wr_cnt, wr_data, fl, acc_tr);
            check($sformatf("m%0d_done_cyc", r), dn_cyc, 12 + 8 * int'(m_n));
            check($sformatf("m%0d_fail", r), fl, m_f);
            check($sformatf("m%0d_nonce", r), nonce[0], m_n);
            check($sformatf("m%0d_hash", r), hash[0], m_h);
            check($sformatf("m%0d_write_data", r), wr_data, {40'b0, m_h});
            check($sformatf("m%0d_store", r), st_prev[0], m_h);
        end

`ifdef BLOCK_MINER_STATS_EN
        exp_bm = 16'd3;
`else
        exp_bm = 16'd0;
`endif
        check("bm_dut0", bm[0], exp_bm);
        check("bm_dut1", bm[1], (exp_bm != 0) ? 16'd1 : 16'd0);
        check("bm_dut2", bm[2], 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/block_miner.md
# block_miner

Proof-of-work engine that sits directly downstream of the `data_registers` store. On `start` it reads the 48-bit transaction and the 8-bit previous hash through the store's read port. It then searches nonces until the 8-bit block hash meets the difficulty target and writes the new hash back as the next `previous_hash`. It drives the store's `access_type`/`wren`/`data_in` inputs and consumes its `result` output.

## Interface
- `DIFFICULTY`, 3: number of leading (MSB) hash bits that must be zero; legal range 1..8.
- `MAX_NONCE`, 255: last nonce tried before giving up; legal range 0..255.
- `clock`  in  1  single clock, rising edge.
- `resetn`  in  1  reset; asynchronous and active-low.
- `start`  in  1  request to mine; sampled only in IDLE.
- `reg_result`  in  48  store read data (combinational from `reg_access_type`).
- `reg_access_type`  out  1  0 = transaction data, 1 = previous hash.
- `reg_wren`  out  1  store write enable.
- `reg_data`  out  48  store write data, `{40'b0, hash}`.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse at end of a run.
- `fail`  out  1  valid with `done`: no nonce met the target.
- `nonce`  out  8  winning (or last tried) nonce; holds until the next run.
- `hash`  out  8  winning (or last computed) hash; holds until the next run.
- `blocks_mined`  out  16  successful-run counter (see Configuration).

## Operation
- States and transitions:
  - IDLE goes to RD_TX on `start`.
  - RD_TX always goes to RD_HASH.
  - RD_HASH always goes to HASH.
  - HASH runs 7 cycles, then goes to CHECK.
  - CHECK goes to WRITE on success.
  - On failure, CHECK goes to HASH with nonce+1 if `nonce != MAX_NONCE`; otherwise it goes to DONE with fail.
  - WRITE always goes to DONE.
  - DONE always goes to IDLE.
- RD_TX: `reg_access_type=0`; latch `reg_result` into `tx` at the cycle end.
- RD_HASH: `reg_access_type=1`; latch `reg_result[7:0]` into `prev`; `nonce=0`.
- HASH: `h` starts at `prev` for each nonce attempt. One byte per cycle, index i=0..6:
  - byte order: b0=tx[47:40], b1=tx[39:32], … b5=tx[7:0], b6=nonce;
  - update: `h_next = ({h[6:0],h[7]} ^ b_i) + 8'h3B` (mod 256).
- CHECK: success iff `h[7:8-DIFFICULTY] == 0`.
- WRITE: `reg_access_type=1`, `reg_wren=1`, `reg_data={40'b0,h}`.
- DONE: `done=1`; `fail=1` only on the give-up path. `fail` clears on the next `start`.
- `start` while `busy` is ignored; it is not queued.
- `reg_wren` is high only in WRITE. `reg_access_type` is 0 in IDLE/RD_TX/HASH/CHECK/DONE.
- Reset values of outputs:
  - all outputs 0: `reg_access_type`, `reg_wren`, `reg_data`, `busy`, `done`, `fail`, `nonce`, `hash`, `blocks_mined`;
  - state IDLE.
- Reset mid-run: asynchronous; `reg_wren` drops immediately. No partial write, no `done`.

## Timing
- Cycle 0 is the edge that samples `start`. Then:
  - RD_TX is cycle 1 and RD_HASH is cycle 2;
  - nonce n occupies HASH cycles 3+8n..9+8n and CHECK cycle 10+8n.
- Success on nonce n: WRITE in cycle 11+8n; `done` in cycle 12+8n; `busy` falls after that cycle.
- Give-up: `done`+`fail` in cycle 11+8·MAX_NONCE; no write.
- Minimum run is 12 cycles. `start` is accepted again in the cycle after DONE.
- The store's result is combinational, so a read needs no wait state. The write lands at the WRITE edge.

## Configuration
- `BLOCK_MINER_STATS_EN` defined: `blocks_mined` increments by 1 on each WRITE and saturates at 16'hFFFF.
- Not defined: counter logic is removed and `blocks_mined` is tied to 0.

## Structure
- Shared package `miner_pkg`:
  - state enum;
  - `HASH_ADD = 8'h3B`;
  - `TX_BYTES = 6`;
  - function `hash_step(h, b)`, also used by the bench model.
- One sub-module, `hash_round`: combinational single-byte step. The FSM, counters and latches stay in `block_miner`.

## Test plan
- Store in reset state (tx=0, prev=8'hFF), DIFFICULTY=3, `start` pulse -> WRITE of `48'h1D` in cycle 11, `done` in cycle 12, `nonce=0`, `hash=8'h1D`, `fail=0`.
- Same data, DIFFICULTY=8 -> `nonce=8'h27`, `hash=8'h00`, WRITE in cycle 323, `done` in cycle 324.
- DIFFICULTY=8, MAX_NONCE=16, same data -> `done`+`fail` in cycle 139, `reg_wren` never high, `nonce=16`.
- Re-pulse `start` in cycles 1..11 of the first scenario -> no effect; exactly one `done` in cycle 12.
- Assert `resetn` low in cycle 7 of the first scenario -> all outputs 0 at once, no write; the store still holds 8'hFF.
- With `BLOCK_MINER_STATS_EN`, three successful runs -> `blocks_mined=3`. Without the macro -> `blocks_mined` stays 0.
